region_highlighter: RTL and testbench

- Parametrised successor to the three-switch OLED column highlighter.
- Divides the OLED frame into NUM_REGIONS equal strips, vertical or horizontal, and lights strips selected by debounced switches.
- Supports priority or union selection, optional blinking, and a registered pixel output.
- Sits between the slide switches and the OLED driver. Consumes the driver's pixel coordinate and returns a 16-bit RGB565 colour one cycle later.

---
 rtl/region_highlighter.sv | 146 ++++++++++++++
 tb/tb_region_highlighter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/region_highlighter.sv
// Splits the OLED frame into equal strips and lights the strips picked by debounced switches.
// Output pixel colour is registered one cycle behind the driver's x/y coordinate.
module region_highlighter #(
  parameter int unsigned NUM_REGIONS     = 3,
  parameter int unsigned SCREEN_W        = 96,
  parameter int unsigned SCREEN_H        = 64,
  parameter int unsigned X_W             = 10,
  parameter int unsigned Y_W             = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned BLINK_PERIOD    = 6250000,
  parameter logic [15:0] FG_COLOUR       = 16'hFFFF,
  parameter logic [15:0] BG_COLOUR       = 16'h0000,
  localparam int unsigned IdxW           = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REGIONS-1:0] SW,
  input  logic                   ORIENT,
  input  logic                   MODE,
  input  logic                   BLINK,
  input  logic [X_W-1:0]         x,
  input  logic [Y_W-1:0]         y,
  output logic [15:0]            olede,
  output logic [NUM_REGIONS-1:0] sw_stable,
  output logic                   any_active,
  output logic [IdxW-1:0]        sel_idx
);

  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CntW-1:0]   DebMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_PERIOD - 1);
  localparam int unsigned StripW = SCREEN_W / NUM_REGIONS;
  localparam int unsigned StripH = SCREEN_H / NUM_REGIONS;

  logic [NUM_REGIONS-1:0] sync1_q, sync2_q;
  logic [NUM_REGIONS-1:0] stable_q, stable_d;
  logic [CntW-1:0]        cnt_q [NUM_REGIONS];
  logic [CntW-1:0]        cnt_d [NUM_REGIONS];
  logic                   any_q, any_d;
  logic [IdxW-1:0]        sel_q, sel_d;
  logic [BlinkW-1:0]      blink_cnt_q, blink_cnt_d;
  logic                   phase_q, phase_d;
  logic [15:0]            olede_q, olede_d;
  logic [IdxW-1:0]        region_x, region_y, region;
  logic                   in_frame, lit;

  // Per-bit debounce: count while the synchronised level disagrees, commit on reaching the limit.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DebMax) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    any_d = |stable_q;
    sel_d = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (stable_q[i]) begin
        sel_d = IdxW'(i);
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Strip boundaries are constants; the last strip absorbs any remainder.
  always_comb begin
    region_x = '0;
    region_y = '0;
    for (int unsigned i = 1; i < NUM_REGIONS; i++) begin
      if (x >= X_W'(i * StripW)) begin
        region_x = IdxW'(i);
      end
      if (y >= Y_W'(i * StripH)) begin
        region_y = IdxW'(i);
      end
    end
  end

  always_comb begin
    region   = ORIENT ? region_y : region_x;
    in_frame = (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    lit      = 1'b0;
    if (in_frame) begin
      if (MODE) begin
        lit = stable_q[region];
      end else begin
        lit = any_q && (region == sel_q);
      end
    end
    if (BLINK && !phase_q) begin
      lit = 1'b0;
    end
    olede_d = lit ? FG_COLOUR : BG_COLOUR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      any_q       <= 1'b0;
      sel_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      olede_q     <= BG_COLOUR;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= SW;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      any_q       <= any_d;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      olede_q     <= olede_d;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign olede      = olede_q;
  assign sw_stable  = stable_q;
  assign any_active = any_q;
  assign sel_idx    = sel_q;

endmodule

// File: tb/tb_region_highlighter.sv
// Directed bench for region_highlighter with short debounce and blink periods.
module tb_region_highlighter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  SW;
  logic        ORIENT, MODE, BLINK;
  logic [9:0]  x;
  logic [6:0]  y;
  logic [15:0] olede;
  logic [2:0]  sw_stable;
  logic        any_active;
  logic [1:0]  sel_idx;

  int checks = 0;
  int errors = 0;

  region_highlighter #(
    .NUM_REGIONS    (3),
    .SCREEN_W       (96),
    .SCREEN_H       (64),
    .X_W            (10),
    .Y_W            (7),
    .DEBOUNCE_CYCLES(4),
    .BLINK_PERIOD   (8),
    .FG_COLOUR      (16'hFFFF),
    .BG_COLOUR      (16'h0000)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW        (SW),
    .ORIENT    (ORIENT),
    .MODE      (MODE),
    .BLINK     (BLINK),
    .x         (x),
    .y         (y),
    .olede     (olede),
    .sw_stable (sw_stable),
    .any_active(any_active),
    .sel_idx   (sel_idx)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic [15:0] exp);
    x = 10'(px);
    y = 7'(py);
    tick(1);
    chk(tag, {16'h0, olede}, {16'h0, exp});
  endtask

  initial begin
    logic [15:0] exp_pix;
    RST = 1'b1; SW = '0; ORIENT = 1'b0; MODE = 1'b0; BLINK = 1'b0; x = '0; y = '0;
    tick(2);
    chk("rst_olede", {16'h0, olede}, 32'h0);
    chk("rst_stable", {29'h0, sw_stable}, 32'h0);
    chk("rst_any", {31'h0, any_active}, 32'h0);
    chk("rst_sel", {30'h0, sel_idx}, 32'h0);
    RST = 1'b0;

    // No switches: every column dark.
    for (int i = 0; i < 96; i++) begin
      pix("sweep_dark", i, 0, 16'h0000);
    end
    chk("idle_stable", {29'h0, sw_stable}, 32'h0);
    chk("idle_any", {31'h0, any_active}, 32'h0);

    // SW[0] commits exactly 6 edges after the raw change.
    SW = 3'b001;
    tick(5);
    chk("deb_early", {29'h0, sw_stable}, 32'h0);
    tick(1);
    chk("deb_commit", {29'h0, sw_stable}, 32'h1);
    chk("status_lag", {31'h0, any_active}, 32'h0);
    tick(1);
    chk("any_on", {31'h0, any_active}, 32'h1);
    chk("sel0", {30'h0, sel_idx}, 32'h0);
    pix("r0_x31", 31, 0, 16'hFFFF);
    pix("r0_x32", 32, 0, 16'h0000);
    pix("r0_x0", 0, 0, 16'hFFFF);

    // Priority then union with SW=110.
    SW = 3'b110;
    tick(7);
    chk("multi_commit", {29'h0, sw_stable}, 32'h6);
    chk("sel1", {30'h0, sel_idx}, 32'h1);
    pix("pri_x31", 31, 0, 16'h0000);
    pix("pri_x32", 32, 0, 16'hFFFF);
    pix("pri_x63", 63, 0, 16'hFFFF);
    pix("pri_x64", 64, 0, 16'h0000);
    MODE = 1'b1;
    pix("uni_x0", 0, 0, 16'h0000);
    pix("uni_x31", 31, 0, 16'h0000);
    pix("uni_x32", 32, 0, 16'hFFFF);
    pix("uni_x95", 95, 0, 16'hFFFF);
    pix("uni_x96", 96, 0, 16'h0000);

    // Rows: S = 21, last strip covers 42..63.
    ORIENT = 1'b1; MODE = 1'b0; SW = 3'b100;
    tick(7);
    chk("sel2", {30'h0, sel_idx}, 32'h2);
    pix("row_y21", 10, 21, 16'h0000);
    pix("row_y41", 10, 41, 16'h0000);
    pix("row_y42", 10, 42, 16'hFFFF);
    pix("row_y63", 10, 63, 16'hFFFF);
    pix("row_y64", 10, 64, 16'h0000);
    pix("row_x100", 100, 50, 16'h0000);
    MODE = 1'b1;
    pix("row_uni_y50", 10, 50, 16'hFFFF);
    pix("row_uni_y20", 10, 20, 16'h0000);

    // A 3-cycle glitch must not commit.
    SW = 3'b110;
    tick(3);
    SW = 3'b100;
    tick(8);
    chk("glitch", {29'h0, sw_stable}, 32'h4);

    // Reset mid-count discards progress.
    SW = 3'b110;
    tick(2);
    SW = 3'b100;
    RST = 1'b1;
    tick(1);
    chk("midrst_stable", {29'h0, sw_stable}, 32'h0);
    chk("midrst_any", {31'h0, any_active}, 32'h0);
    chk("midrst_sel", {30'h0, sel_idx}, 32'h0);
    chk("midrst_olede", {16'h0, olede}, 32'h0);
    RST = 1'b0;
    tick(5);
    chk("rerun_early", {29'h0, sw_stable}, 32'h0);
    tick(1);
    chk("rerun_commit", {29'h0, sw_stable}, 32'h4);

    // Blink: half-period 8 cycles, phase on right after reset.
    SW = 3'b001; ORIENT = 1'b0; MODE = 1'b0; BLINK = 1'b1; x = 10'd10; y = 7'd0;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick(1);
      exp_pix = (n >= 8 && (((n - 1) / 8) % 2 == 0)) ? 16'hFFFF : 16'h0000;
      chk($sformatf("blink_n%0d", n), {16'h0, olede}, {16'h0, exp_pix});
    end
    BLINK = 1'b0;
    for (int n = 0; n < 16; n++) begin
      tick(1);
      chk("noblink", {16'h0, olede}, 32'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
